// File: rtl/spr_line_scan.sv
// spr_line_scan: per-scanline sprite attribute scanner.
//
// Walks sprite RAM one 4-byte record at a time, range-checks each sprite's
// vertical position against the latched target line and writes every hit
// into a compact per-line list consumed by the line-buffer renderer.
//
// Handshake: start is a single-cycle request that is honoured only in IDLE
// (it is ignored while busy and during the done cycle). busy is high from the
// cycle after an accepted start until the scan ends. done pulses for exactly
// one cycle with busy low. list_we is a one-cycle write strobe with no back
// pressure; list_addr/list_data are meaningful only while list_we is high.
//
// Ports:
//   pixel_clk        clock, rising edge
//   SPR_ROM_ADDR_RST asynchronous active-high reset
//   start, vline     scan request and target line (sampled on start)
//   flip             screen flip (used only when SPR_FLIP_EN is defined)
//   ram_addr, ram_d  sprite RAM byte address / read data (1-cycle latency)
//   list_we, list_addr, list_data   list write port
//   list_cnt, ovf    hits written / overflow, held until next start
//   busy, done       scan status
//
// Build option: define SPR_FLIP_EN to mirror row and hpos when flip was high
// on the start cycle.
//
// The current FSM state is available on the internal signal state_q for
// checker binding.

module spr_line_scan #(
  parameter int NUM_SPR      = 512,
  parameter int MAX_PER_LINE = 32,
  parameter int SPR_H        = 16
) (
  input  logic        pixel_clk,
  input  logic        SPR_ROM_ADDR_RST,
  input  logic        start,
  input  logic [7:0]  vline,
  input  logic        flip,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_d,
  output logic        list_we,
  output logic [5:0]  list_addr,
  output logic [26:0] list_data,
  output logic [5:0]  list_cnt,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_EVAL, S_DONE
  } state_t;

  localparam logic [8:0] LAST_N  = 9'(NUM_SPR - 1);
  localparam logic [5:0] MAX_CNT = 6'(MAX_PER_LINE);
  localparam logic [7:0] SPR_H_B = 8'(SPR_H);

  state_t      state_q, state_d;
  logic [8:0]  n_q, n_d;
  logic [7:0]  vline_q, vline_d;
  logic [7:0]  idx_lo_q, idx_lo_d;
  logic [7:0]  xdat_q, xdat_d;
  logic [7:0]  hpos_lo_q, hpos_lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  ram_off;

  // EVAL arithmetic; ram_d carries vpos (byte3) during EVAL.
  logic [7:0]  dy;
  logic        hit;
  logic [3:0]  row_out;
  logic [8:0]  hpos_raw, hpos_out;

  assign dy       = vline_q - ram_d;
  assign hit      = (dy < SPR_H_B);
  assign hpos_raw = {xdat_q[0], hpos_lo_q};

`ifdef SPR_FLIP_EN
  localparam logic [3:0] ROW_MAX = 4'(SPR_H - 1);
  logic flip_q, flip_d;

  assign row_out  = flip_q ? (ROW_MAX - dy[3:0]) : dy[3:0];
  assign hpos_out = flip_q ? (9'h1F0 - hpos_raw) : hpos_raw;
`else
  logic unused_flip;

  assign unused_flip = flip;
  assign row_out     = dy[3:0];
  assign hpos_out    = hpos_raw;
`endif

  always_ff @(posedge pixel_clk or posedge SPR_ROM_ADDR_RST) begin
    if (SPR_ROM_ADDR_RST) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      vline_q   <= '0;
      idx_lo_q  <= '0;
      xdat_q    <= '0;
      hpos_lo_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef SPR_FLIP_EN
      flip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      vline_q   <= vline_d;
      idx_lo_q  <= idx_lo_d;
      xdat_q    <= xdat_d;
      hpos_lo_q <= hpos_lo_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
`ifdef SPR_FLIP_EN
      flip_q    <= flip_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    vline_d   = vline_q;
    idx_lo_d  = idx_lo_q;
    xdat_d    = xdat_q;
    hpos_lo_d = hpos_lo_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
`ifdef SPR_FLIP_EN
    flip_d    = flip_q;
`endif
    ram_off   = 2'd0;
    list_we   = 1'b0;
    list_addr = '0;
    list_data = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vline_d = vline;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          n_d     = '0;
`ifdef SPR_FLIP_EN
          flip_d  = flip;
`endif
          state_d = S_F0;
        end
      end
      S_F0: begin
        busy    = 1'b1;
        ram_off = 2'd0;
        state_d = S_F1;
      end
      // Each fetch state captures the byte addressed in the previous state.
      S_F1: begin
        busy     = 1'b1;
        ram_off  = 2'd1;
        idx_lo_d = ram_d;
        state_d  = S_F2;
      end
      S_F2: begin
        busy    = 1'b1;
        ram_off = 2'd2;
        xdat_d  = ram_d;
        state_d = S_F3;
      end
      S_F3: begin
        busy      = 1'b1;
        ram_off   = 2'd3;
        hpos_lo_d = ram_d;
        state_d   = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        if (hit && (cnt_q >= MAX_CNT)) begin
          // List full: flag and abandon the rest of the scan.
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (hit) begin
            list_we   = 1'b1;
            list_addr = cnt_q;
            list_data = {row_out, xdat_q[4:1], hpos_out, xdat_q[7:6], idx_lo_q};
            cnt_d     = cnt_q + 6'd1;
          end
          if (n_q == LAST_N) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + 9'd1;
            state_d = S_F0;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_addr = {n_q, ram_off};
  assign list_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_spr_line_scan.sv
module tb_spr_line_scan;

  localparam int NUM_SPR = 4;
  localparam int MAX_PL  = 2;

  // clock / reset
  logic        pixel_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vline;
  logic        flip;
  logic [10:0] ram_addr;
  logic [7:0]  ram_d;
  logic        list_we;
  logic [5:0]  list_addr;
  logic [26:0] list_data;
  logic [5:0]  list_cnt;
  logic        busy;
  logic        done;
  logic        ovf;

  always #5 pixel_clk = ~pixel_clk;

  spr_line_scan #(.NUM_SPR(NUM_SPR), .MAX_PER_LINE(MAX_PL), .SPR_H(16)) dut (
    .pixel_clk(pixel_clk), .SPR_ROM_ADDR_RST(rst), .start(start), .vline(vline),
    .flip(flip), .ram_addr(ram_addr), .ram_d(ram_d), .list_we(list_we),
    .list_addr(list_addr), .list_data(list_data), .list_cnt(list_cnt),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // sprite RAM model, one-cycle read latency
  logic [7:0] mem [0:2047];
  always @(posedge pixel_clk) ram_d <= mem[ram_addr];

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  int t0 = 0;
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;

  // scoreboard entry: {cycle offset[7:0], list_addr[5:0], list_data[26:0]}
  logic [40:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [26:0] pack(input logic [3:0] row, input logic [3:0] col,
                                       input logic [8:0] hp, input logic [9:0] idx);
    return {row, col, hp, idx};
  endfunction

  task automatic push_exp(input int k, input logic [5:0] a, input logic [26:0] d);
    exp_q.push_back({8'(k), a, d});
  endtask

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = ((i % 4) == 3) ? 8'h80 : 8'h00;
  endtask

  task automatic set_spr(input int n, input logic [7:0] idx, input logic [7:0] xd,
                         input logic [7:0] hp, input logic [7:0] vp);
    mem[4*n]   = idx;
    mem[4*n+1] = xd;
    mem[4*n+2] = hp;
    mem[4*n+3] = vp;
  endtask

  // monitor: pop and compare on every list write
  always @(negedge pixel_clk) begin
    if (done === 1'b1) done_cnt++;
    if (list_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {35'd0, list_addr, list_data}, 64'h0);
      end else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        check("we_cycle", 64'(cyc - t0), {56'd0, e[40:33]});
        check("we_addr", {58'd0, list_addr}, {58'd0, e[32:27]});
        check("we_data", {37'd0, list_data}, {37'd0, e[26:0]});
      end
    end
  end

  // Runs one scan; r1/r2 are cycle offsets at which a spurious start is pulsed.
  task automatic run_scan(input logic [7:0] vl, input logic fl, input int exp_done,
                          input int r1, input int r2, input logic [5:0] exp_cnt,
                          input logic exp_ovf);
    bit got;
    got = 0;
    @(negedge pixel_clk);
    t0 = cyc;
    vline = vl;
    flip  = fl;
    start = 1'b1;
    check("busy_start_cycle", {63'd0, busy}, 64'd0);
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge pixel_clk);
      start = (k == r1 || k == r2);
      if (start) begin
        vline = 8'hAA;
        flip  = ~fl;
      end
      if (done === 1'b1) begin
        got = 1;
        check("done_cycle", 64'(cyc - t0), 64'(exp_done));
        check("busy_in_done", {63'd0, busy}, 64'd0);
      end else begin
        check("busy_scan", {63'd0, busy}, 64'd1);
        if (((k - 1) % 5) < 4)
          check("ram_addr", {53'd0, ram_addr}, 64'(4 * ((k - 1) / 5) + ((k - 1) % 5)));
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 64'd0, 64'd1);
    check("list_cnt", {58'd0, list_cnt}, {58'd0, exp_cnt});
    check("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge pixel_clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
    check("list_cnt_hold", {58'd0, list_cnt}, {58'd0, exp_cnt});
    check("ovf_hold", {63'd0, ovf}, {63'd0, exp_ovf});
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    vline = 8'h00;
    flip  = 1'b0;
    clear_mem();

    // reset state
    repeat (3) @(negedge pixel_clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_list_we", {63'd0, list_we}, 64'd0);
    check("rst_list_cnt", {58'd0, list_cnt}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_ram_addr", {53'd0, ram_addr}, 64'd0);
    check("rst_list_addr", {58'd0, list_addr}, 64'd0);
    check("rst_list_data", {37'd0, list_data}, 64'd0);
    rst = 1'b0;
    @(negedge pixel_clk);

    // single hit on sprite 2
    clear_mem();
    set_spr(2, 8'h34, 8'hC7, 8'h80, 8'h10);
    push_exp(15, 6'd0, pack(4'h5, 4'h3, 9'h180, 10'h334));
    run_scan(8'h15, 1'b0, 21, 0, 0, 6'd1, 1'b0);

    // wrap-around hit
    clear_mem();
    set_spr(1, 8'h01, 8'h00, 8'h20, 8'hF8);
    push_exp(10, 6'd0, pack(4'hB, 4'h0, 9'h020, 10'h001));
    run_scan(8'h03, 1'b0, 21, 0, 0, 6'd1, 1'b0);

    // just past the bottom of the wrapped sprite: no write
    run_scan(8'h08, 1'b0, 21, 0, 0, 6'd0, 1'b0);

    // overflow: all four hit, list holds two; spurious start mid-scan
    clear_mem();
    for (int i = 0; i < 4; i++) set_spr(i, 8'(8'h10 + i), 8'h00, 8'(8'h40 + i), 8'h10);
    push_exp(5, 6'd0, pack(4'h0, 4'h0, 9'h040, 10'h010));
    push_exp(10, 6'd1, pack(4'h0, 4'h0, 9'h041, 10'h011));
    run_scan(8'h10, 1'b0, 16, 7, 0, 6'd2, 1'b1);

    // ovf cleared by next start; start during busy and during done ignored
    clear_mem();
    set_spr(2, 8'h34, 8'hC7, 8'h80, 8'h10);
    push_exp(15, 6'd0, pack(4'h5, 4'h3, 9'h180, 10'h334));
    run_scan(8'h15, 1'b0, 21, 9, 21, 6'd1, 1'b0);

    // asynchronous reset mid-scan
    clear_mem();
    set_spr(0, 8'h22, 8'h06, 8'h11, 8'h20);
    push_exp(5, 6'd0, pack(4'h0, 4'h3, 9'h011, 10'h022));
    @(negedge pixel_clk);
    t0 = cyc;
    vline = 8'h20;
    start = 1'b1;
    @(negedge pixel_clk);
    start = 1'b0;
    repeat (6) @(negedge pixel_clk);
    check("pre_rst_cnt", {58'd0, list_cnt}, 64'd1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_cnt", {58'd0, list_cnt}, 64'd0);
    check("midrst_ram_addr", {53'd0, ram_addr}, 64'd0);
    check("midrst_list_we", {63'd0, list_we}, 64'd0);
    repeat (2) @(negedge pixel_clk);
    rst = 1'b0;
    repeat (30) @(negedge pixel_clk);
    check("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    check("rst_exp_q_empty", 64'(exp_q.size()), 64'd0);

    // rescan from sprite 0
    push_exp(5, 6'd0, pack(4'h0, 4'h3, 9'h011, 10'h022));
    run_scan(8'h20, 1'b0, 21, 0, 0, 6'd1, 1'b0);

    // flip request
    clear_mem();
    set_spr(0, 8'h05, 8'h00, 8'h80, 8'h10);
`ifdef SPR_FLIP_EN
    push_exp(5, 6'd0, pack(4'hD, 4'h0, 9'h170, 10'h005));
`else
    push_exp(5, 6'd0, pack(4'h2, 4'h0, 9'h080, 10'h005));
`endif
    run_scan(8'h12, 1'b1, 21, 0, 0, 6'd1, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
